// File: rtl/corr_frame_sequencer.sv
// rtl/corr_frame_sequencer.sv - frames func_1/func_2 into zero-padded NFFT-point frames for the shared FFT core
module corr_frame_sequencer #(
    parameter int NFFT  = 256,
    parameter int LEN_W = 13
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic [LEN_W-1:0] N1,
    input  logic [LEN_W-1:0] N2,
    output logic             idle,
    output logic             len_err,
    output logic             done,
    input  logic [31:0]      func_1_tdata,
    input  logic             func_1_tvalid,
    output logic             func_1_tready,
    input  logic [31:0]      func_2_tdata,
    input  logic             func_2_tvalid,
    output logic             func_2_tready,
    output logic [31:0]      fft_tdata,
    output logic             fft_tvalid,
    input  logic             fft_tready,
    output logic             fft_tlast,
    output logic             fft_tuser,
    input  logic             corr_tvalid,
    input  logic             corr_tready,
    input  logic             corr_tlast
);

    localparam int CW = $clog2(NFFT) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_F1_DATA = 3'd1;
    localparam logic [2:0] S_F1_PAD  = 3'd2;
    localparam logic [2:0] S_F2_DATA = 3'd3;
    localparam logic [2:0] S_F2_PAD  = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    localparam logic [CW-1:0]  CNT_LAST = CW'(NFFT - 1);
    localparam logic [LEN_W:0] NFFT_P1  = (LEN_W + 1)'(NFFT + 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] n1_r;
    logic [CW-1:0] n2_r;
    logic          len_err_r;
    logic          done_r;
    logic          len_ok;
    logic          beat;
    logic          in_frame;
    logic [LEN_W:0] len_sum;

    // N1+N2-1 <= NFFT rewritten as N1+N2 <= NFFT+1 so no subtraction can wrap
    assign len_sum = {1'b0, N1} + {1'b0, N2};
    assign len_ok  = (N1 != '0) && (N2 != '0) && (len_sum <= NFFT_P1);

    assign in_frame = (state == S_F1_DATA) || (state == S_F1_PAD) ||
                      (state == S_F2_DATA) || (state == S_F2_PAD);

    always_comb begin
        fft_tdata     = '0;
        fft_tvalid    = 1'b0;
        fft_tuser     = 1'b0;
        func_1_tready = 1'b0;
        func_2_tready = 1'b0;
        case (state)
            S_F1_DATA: begin
                fft_tdata     = func_1_tdata;
                fft_tvalid    = func_1_tvalid;
                func_1_tready = fft_tready;
            end
            S_F1_PAD: begin
                fft_tvalid = 1'b1;
            end
            S_F2_DATA: begin
                fft_tdata     = func_2_tdata;
                fft_tvalid    = func_2_tvalid;
                func_2_tready = fft_tready;
                fft_tuser     = 1'b1;
            end
            S_F2_PAD: begin
                fft_tvalid = 1'b1;
                fft_tuser  = 1'b1;
            end
            default: ;
        endcase
    end

    assign fft_tlast = in_frame && (cnt == CNT_LAST);
    assign beat      = fft_tvalid && fft_tready;
    assign idle      = (state == S_IDLE);
    assign len_err   = len_err_r;
    assign done      = done_r;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            n1_r      <= '0;
            n2_r      <= '0;
            len_err_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            len_err_r <= 1'b0;
            done_r    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            // valid lengths never exceed NFFT, so they fit the counter width
                            n1_r  <= N1[CW-1:0];
                            n2_r  <= N2[CW-1:0];
                            cnt   <= '0;
                            state <= S_F1_DATA;
                        end else begin
                            len_err_r <= 1'b1;
                        end
                    end
                end
                S_F1_DATA: begin
                    if (beat) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_F2_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (cnt == n1_r - 1'b1)
                                state <= S_F1_PAD;
                        end
                    end
                end
                S_F1_PAD: begin
                    if (beat) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_F2_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_F2_DATA: begin
                    if (beat) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_WAIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (cnt == n2_r - 1'b1)
                                state <= S_F2_PAD;
                        end
                    end
                end
                S_F2_PAD: begin
                    if (beat) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_WAIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (corr_tvalid && corr_tready && corr_tlast) begin
                        done_r <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corr_frame_sequencer.sv
// tb/tb_corr_frame_sequencer.sv - directed self-checking bench for corr_frame_sequencer (NFFT=8)
module tb_corr_frame_sequencer;

    localparam int NFFT  = 8;
    localparam int LEN_W = 13;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] N1 = '0;
    logic [LEN_W-1:0] N2 = '0;
    logic             idle, len_err, done;
    logic [31:0]      func_1_tdata = '0;
    logic             func_1_tvalid = 1'b0;
    logic             func_1_tready;
    logic [31:0]      func_2_tdata = '0;
    logic             func_2_tvalid = 1'b0;
    logic             func_2_tready;
    logic [31:0]      fft_tdata;
    logic             fft_tvalid;
    logic             fft_tready = 1'b0;
    logic             fft_tlast, fft_tuser;
    logic             corr_tvalid = 1'b0;
    logic             corr_tready = 1'b0;
    logic             corr_tlast = 1'b0;

    int checks = 0;
    int passes = 0;

    logic [33:0] beats[$];
    int          idx1, idx2;
    bit          hold1, hold2;
    bit          prev_stall;
    logic [33:0] prev_out;
    int          stall_bad;

    corr_frame_sequencer #(.NFFT(NFFT), .LEN_W(LEN_W)) dut (
        .aclk(aclk), .areset(areset), .start(start), .N1(N1), .N2(N2),
        .idle(idle), .len_err(len_err), .done(done),
        .func_1_tdata(func_1_tdata), .func_1_tvalid(func_1_tvalid), .func_1_tready(func_1_tready),
        .func_2_tdata(func_2_tdata), .func_2_tvalid(func_2_tvalid), .func_2_tready(func_2_tready),
        .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid), .fft_tready(fft_tready),
        .fft_tlast(fft_tlast), .fft_tuser(fft_tuser),
        .corr_tvalid(corr_tvalid), .corr_tready(corr_tready), .corr_tlast(corr_tlast)
    );

    always #5 aclk = ~aclk;

    // Expected frame beat k (0/1), position j, for a signal of length n: {tuser, tlast, tdata}
    function automatic logic [33:0] exp_beat(input int k, input int j, input int n);
        logic [31:0] d;
        logic        u;
        u = (k != 0);
        d = (j < n) ? ((k != 0 ? 32'h2000_0000 : 32'h1000_0000) + 32'(j)) : 32'h0;
        return {u, (j == NFFT - 1), d};
    endfunction

    task automatic clear_run();
        beats.delete();
        idx1 = 0; idx2 = 0;
        hold1 = 0; hold2 = 0;
        prev_stall = 0;
        stall_bad = 0;
    endtask

    // One clock: entered at posedge+1, drives inputs, observes at negedge, returns at posedge+1
    task automatic drive_cycle(input bit rnd, input bit corr, input bit st, input bit rst);
        bit v1, v2, rdy;
        v1  = hold1 || (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        v2  = hold2 || (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        areset        = rst;
        start         = st;
        N1            = st ? 13'd1 : 13'h1abc;
        N2            = st ? 13'd1 : 13'h0777;
        func_1_tvalid = v1;
        func_1_tdata  = 32'h1000_0000 + 32'(idx1);
        func_2_tvalid = v2;
        func_2_tdata  = 32'h2000_0000 + 32'(idx2);
        fft_tready    = rdy;
        corr_tvalid   = corr;
        corr_tready   = corr;
        corr_tlast    = corr;
        @(negedge aclk);
        if (prev_stall && (!fft_tvalid || {fft_tuser, fft_tlast, fft_tdata} !== prev_out))
            stall_bad++;
        prev_stall = fft_tvalid && !fft_tready;
        prev_out   = {fft_tuser, fft_tlast, fft_tdata};
        if (fft_tvalid && fft_tready) beats.push_back({fft_tuser, fft_tlast, fft_tdata});
        hold1 = func_1_tvalid && !func_1_tready;
        hold2 = func_2_tvalid && !func_2_tready;
        if (func_1_tvalid && func_1_tready) idx1++;
        if (func_2_tvalid && func_2_tready) idx2++;
        @(posedge aclk); #1;
    endtask

    task automatic do_start(input int n1, input int n2);
        areset = 1'b0;
        corr_tvalid = 1'b0; corr_tready = 1'b0; corr_tlast = 1'b0;
        fft_tready = 1'b1;
        func_1_tvalid = 1'b1;
        func_2_tvalid = 1'b1;
        start = 1'b1;
        N1 = LEN_W'(n1);
        N2 = LEN_W'(n2);
        @(posedge aclk); #1;
        start = 1'b0;
        N1 = 13'h1fff;
        N2 = 13'h1fff;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        fft_tready = 1'b1; func_1_tvalid = 1'b1; func_2_tvalid = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b1 || len_err !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_status: idle=%b len_err=%b done=%b, required 1 0 0", idle, len_err, done);
        else passes++;
        checks++;
        if (fft_tvalid !== 1'b0 || fft_tlast !== 1'b0 || fft_tuser !== 1'b0 || fft_tdata !== 32'h0)
            $display("FAIL reset_fft: valid=%b last=%b user=%b data=%h, required 0 0 0 0",
                     fft_tvalid, fft_tlast, fft_tuser, fft_tdata);
        else passes++;
        checks++;
        if (func_1_tready !== 1'b0 || func_2_tready !== 1'b0)
            $display("FAIL reset_tready: r1=%b r2=%b, required 0 0", func_1_tready, func_2_tready);
        else passes++;
        @(posedge aclk); #1;
    endtask

    task automatic test_basic();
        clear_run();
        do_start(3, 2);
        checks++;
        if (idle !== 1'b0 || func_1_tready !== fft_tready || func_2_tready !== 1'b0)
            $display("FAIL basic_accept: idle=%b r1=%b r2=%b, required 0 1 0", idle, func_1_tready, func_2_tready);
        else passes++;
        repeat (16) drive_cycle(0, 0, 0, 0);
        checks++;
        if (beats.size() != 16)
            $display("FAIL basic_throughput: beats=%0d in 16 cycles, required 16", beats.size());
        else passes++;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (j >= beats.size() || beats[j] !== exp_beat(j / 8, j % 8, (j < 8) ? 3 : 2))
                $display("FAIL basic_beat%0d: got %h, required %h", j,
                         (j < beats.size()) ? beats[j] : 34'h0, exp_beat(j / 8, j % 8, (j < 8) ? 3 : 2));
            else passes++;
        end
        checks++;
        if (fft_tvalid !== 1'b0 || idle !== 1'b0 || func_1_tready !== 1'b0 || func_2_tready !== 1'b0)
            $display("FAIL basic_wait: valid=%b idle=%b r1=%b r2=%b, required 0 0 0 0",
                     fft_tvalid, idle, func_1_tready, func_2_tready);
        else passes++;
        drive_cycle(0, 1, 0, 0);
        checks++;
        if (done !== 1'b1 || idle !== 1'b1)
            $display("FAIL basic_done: done=%b idle=%b, required 1 1", done, idle);
        else passes++;
        drive_cycle(0, 0, 0, 0);
        checks++;
        if (done !== 1'b0)
            $display("FAIL basic_done_pulse: done=%b, required 0", done);
        else passes++;
    endtask

    task automatic test_len_err();
        int n1s[2] = '{0, 6};
        int n2s[2] = '{3, 4};
        for (int i = 0; i < 2; i++) begin
            do_start(n1s[i], n2s[i]);
            checks++;
            if (len_err !== 1'b1 || idle !== 1'b1 || func_1_tready !== 1'b0 || fft_tvalid !== 1'b0)
                $display("FAIL len_err_%0d: len_err=%b idle=%b r1=%b valid=%b, required 1 1 0 0",
                         i, len_err, idle, func_1_tready, fft_tvalid);
            else passes++;
            @(posedge aclk); #1;
            checks++;
            if (len_err !== 1'b0 || idle !== 1'b1)
                $display("FAIL len_err_pulse_%0d: len_err=%b idle=%b, required 0 1", i, len_err, idle);
            else passes++;
        end
    endtask

    task automatic test_no_pad();
        clear_run();
        do_start(8, 1);
        repeat (16) drive_cycle(0, 0, 0, 0);
        checks++;
        if (beats.size() != 16)
            $display("FAIL nopad_count: beats=%0d, required 16", beats.size());
        else passes++;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (j >= beats.size() || beats[j] !== exp_beat(j / 8, j % 8, (j < 8) ? 8 : 1))
                $display("FAIL nopad_beat%0d: got %h, required %h", j,
                         (j < beats.size()) ? beats[j] : 34'h0, exp_beat(j / 8, j % 8, (j < 8) ? 8 : 1));
            else passes++;
        end
        drive_cycle(0, 1, 0, 0);
        checks++;
        if (done !== 1'b1 || idle !== 1'b1)
            $display("FAIL nopad_done: done=%b idle=%b, required 1 1", done, idle);
        else passes++;
    endtask

    task automatic test_backpressure();
        int cyc;
        clear_run();
        do_start(5, 4);
        cyc = 0;
        while (beats.size() < 16 && cyc < 400) begin
            drive_cycle(1, 0, 0, 0);
            cyc++;
        end
        checks++;
        if (beats.size() != 16)
            $display("FAIL bp_timeout: beats=%0d after %0d cycles, required 16", beats.size(), cyc);
        else passes++;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (j >= beats.size() || beats[j] !== exp_beat(j / 8, j % 8, (j < 8) ? 5 : 4))
                $display("FAIL bp_beat%0d: got %h, required %h", j,
                         (j < beats.size()) ? beats[j] : 34'h0, exp_beat(j / 8, j % 8, (j < 8) ? 5 : 4));
            else passes++;
        end
        checks++;
        if (stall_bad != 0)
            $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", stall_bad);
        else passes++;
        checks++;
        if (idx1 != 5 || idx2 != 4)
            $display("FAIL bp_consumed: func_1=%0d func_2=%0d, required 5 4", idx1, idx2);
        else passes++;
        drive_cycle(0, 1, 0, 0);
        checks++;
        if (done !== 1'b1)
            $display("FAIL bp_done: done=%b, required 1", done);
        else passes++;
    endtask

    task automatic test_ignored();
        clear_run();
        do_start(3, 2);
        for (int c = 0; c < 16; c++)
            drive_cycle(0, (c == 1), (c == 12), 0);
        checks++;
        if (beats.size() != 16)
            $display("FAIL ign_count: beats=%0d, required 16", beats.size());
        else passes++;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (j >= beats.size() || beats[j] !== exp_beat(j / 8, j % 8, (j < 8) ? 3 : 2))
                $display("FAIL ign_beat%0d: got %h, required %h", j,
                         (j < beats.size()) ? beats[j] : 34'h0, exp_beat(j / 8, j % 8, (j < 8) ? 3 : 2));
            else passes++;
        end
        checks++;
        if (idle !== 1'b0 || fft_tvalid !== 1'b0 || done !== 1'b0)
            $display("FAIL ign_wait: idle=%b valid=%b done=%b, required 0 0 0", idle, fft_tvalid, done);
        else passes++;
        drive_cycle(0, 1, 0, 0);
        drive_cycle(0, 0, 0, 0);
        checks++;
        if (idle !== 1'b1 || done !== 1'b0)
            $display("FAIL ign_end: idle=%b done=%b, required 1 0", idle, done);
        else passes++;
    endtask

    task automatic test_abort();
        clear_run();
        do_start(3, 2);
        repeat (3) drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1);
        checks++;
        if (idle !== 1'b1 || fft_tvalid !== 1'b0 || func_1_tready !== 1'b0 || func_2_tready !== 1'b0)
            $display("FAIL abort_state: idle=%b valid=%b r1=%b r2=%b, required 1 0 0 0",
                     idle, fft_tvalid, func_1_tready, func_2_tready);
        else passes++;
        clear_run();
        do_start(3, 2);
        repeat (16) drive_cycle(0, 0, 0, 0);
        checks++;
        if (beats.size() != 16)
            $display("FAIL abort_rerun_count: beats=%0d, required 16", beats.size());
        else passes++;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (j >= beats.size() || beats[j] !== exp_beat(j / 8, j % 8, (j < 8) ? 3 : 2))
                $display("FAIL abort_beat%0d: got %h, required %h", j,
                         (j < beats.size()) ? beats[j] : 34'h0, exp_beat(j / 8, j % 8, (j < 8) ? 3 : 2));
            else passes++;
        end
        drive_cycle(0, 1, 0, 0);
        checks++;
        if (done !== 1'b1 || idle !== 1'b1)
            $display("FAIL abort_done: done=%b idle=%b, required 1 1", done, idle);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_err();
        test_no_pad();
        test_backpressure();
        test_ignored();
        test_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
